inst_fetch_stage: RTL
=====================

Name: inst_fetch_stage

Overview:
- Initiator side of the instruction-memory read interface: owns the PC, drives the instruction address each cycle and captures the returned word into the IF/ID pipeline register.
- Sits between the combinational instruction memory and the ID stage of the pipelined CPU.
- Handles sequential fetch, branch/jump redirects, load-use stalls and flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, bubble word inserted on flush/redirect.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- InstAddr  out  32  address to instruction memory; always equals PC (combinational from the PC register).
- Inst  in  32  instruction word returned combinationally for InstAddr, valid in the same cycle.
- Stall  in  1  hold PC and IF/ID (load-use hazard from ID).
- Flush  in  1  replace the IF/ID contents with a bubble next edge.
- BranchTaken  in  1  branch resolved taken in EX.
- BranchTarget  in  32  target for BranchTaken.
- Jump  in  1  jump decoded in ID.
- JumpTarget  in  32  target for Jump.
- IF_ID_PC  out  32  PC of the held instruction.
- IF_ID_PCPlus4  out  32  IF_ID_PC + 4.
- IF_ID_Inst  out  32  held instruction.
- IF_ID_Valid  out  1  1 = real instruction, 0 = bubble.
- TargetMisalign  out  1  sticky flag: a redirect target had bits[1:0] != 0.
- FetchCount  out  32  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - PC = RESET_PC.
  - IF_ID_PC = 0, IF_ID_PCPlus4 = 4, IF_ID_Inst = NOP_INST, IF_ID_Valid = 0.
  - TargetMisalign = 0, FetchCount = 0.
  - First fetch at RESET_PC on the first edge after reset deasserts.
- Next-PC selection, evaluated each edge in strict priority:
  1. BranchTaken: PC <= {BranchTarget[31:2], 2'b00}; IF/ID <= bubble.
  2. Jump: PC <= {JumpTarget[31:2], 2'b00}; IF/ID <= bubble.
  3. Stall: PC and the whole IF/ID register hold.
  4. Otherwise: PC <= PC + 4 (mod 2^32; wraps 0xFFFFFFFC -> 0); IF/ID <= {PC, PC+4, Inst, 1}.
- A redirect always overrides Stall, because the branch is older than the stalled instruction.
- Flush:
  - Forces IF/ID to bubble: Inst = NOP_INST, Valid = 0, PC fields hold their old values.
  - Flush with Stall: the bubble wins; PC still holds.
  - Flush alone does not change PC selection.
- Bubble definition: IF_ID_Inst = NOP_INST, IF_ID_Valid = 0; IF_ID_PC and IF_ID_PCPlus4 unchanged.
- Latency: a word addressed in cycle n appears on the IF_ID_* outputs after the edge ending cycle n (1 cycle).
- Redirect penalty: 1 bubble for Jump. For BranchTaken, the instruction in ID is killed by the downstream ID/EX flush; this block inserts only the IF/ID bubble.
- TargetMisalign:
  - Set on the edge where the winning redirect target has bits[1:0] != 0.
  - Cleared only by reset; the PC is still forced word-aligned.
- FetchCount:
  - Increments by 1 on each edge where IF_ID_Valid is loaded with 1.
  - Wraps at 2^32.
  - Never counts bubbles or stalled cycles.
- BranchTaken and Jump together: the branch wins, the jump is discarded and the target is never fetched.
- Out-of-range addresses return 0 from memory; this block treats that word as an ordinary instruction with Valid = 1.

Decomposition:
- Shared CPU package holds:
  - constants NOP_INST and RESET_PC;
  - the PC-select encoding PC_SEQ, PC_BRANCH, PC_JUMP, PC_HOLD, also used by hazard-unit debug outputs.
- One sub-module: if_id_reg, the pipeline register with hold/bubble controls and async reset. The PC logic and next-PC mux stay in the top.

Test Plan:
- Reset release, memory model returning 0x20080002 at 0x0 and 0x20090001 at 0x4, no control inputs -> InstAddr sequence 0x0, 0x4, 0x8; after the 1st edge IF_ID_Inst = 0x20080002, Valid = 1, IF_ID_PCPlus4 = 0x4; FetchCount = 3 after 3 edges.
- Stall high for 2 cycles at PC = 0x14 -> InstAddr stays 0x14 and IF/ID holds the 0x10 instruction for 2 edges; PC = 0x18 on the next edge after Stall drops; FetchCount does not advance while stalled.
- Jump = 1, JumpTarget = 0x50 at PC = 0x20 -> next InstAddr = 0x50, IF_ID_Valid = 0, IF_ID_Inst = 0; the edge after that latches the 0x50 word with Valid = 1.
- BranchTaken = 1 with target 0x08, together with Jump (target 0x50) and Stall at PC = 0x3C -> InstAddr = 0x08, bubble in IF/ID, target 0x50 never fetched.
- Redirect target 0x0000_0046 -> InstAddr = 0x44 and TargetMisalign = 1; the flag stays set until reset; Flush the following cycle -> IF_ID_Valid = 0 while PC continues to 0x48.
- Assert reset asynchronously mid-cycle at PC = 0x30 with Stall high -> all outputs reach reset values before the next edge; fetch restarts at RESET_PC; PC wrap check: force PC = 0xFFFFFFFC -> next InstAddr = 0x0.

Source files
------------

// File: rtl/inst_fetch_stage_pkg.sv
// Shared CPU constants and the next-PC select encoding.
// The hazard-unit debug outputs also use this encoding.
package inst_fetch_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_HOLD   = 2'd3
  } pc_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble beats hold, and hold beats load.
// A bubble keeps the PC fields and only clears the instruction and valid.
module if_id_reg
  import inst_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_pc       <= 32'h0000_0000;
      id_pc_plus4 <= 32'h0000_0004;
      id_inst     <= NOP;
      id_valid    <= 1'b0;
    end else if (bubble) begin
      id_inst  <= NOP;
      id_valid <= 1'b0;
    end else if (!hold) begin
      id_pc       <= pc;
      id_pc_plus4 <= pc + 32'd4;
      id_inst     <= inst;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch: owns the PC, addresses instruction memory and fills IF/ID.
// Redirects override stalls because the redirecting instruction is older.
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = inst_fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = inst_fetch_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] InstAddr,
  input  logic [31:0] Inst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PCPlus4,
  output logic [31:0] IF_ID_Inst,
  output logic        IF_ID_Valid,
  output logic        TargetMisalign,
  output logic [31:0] FetchCount
);

  logic [31:0] pc_q, pc_d;
  logic        misalign_q;
  logic [31:0] fetch_count_q;
  pc_sel_e     pc_sel;
  logic [31:0] redirect_target;
  logic        redirect;

  always_comb begin
    pc_sel = PC_SEQ;
    if (BranchTaken)  pc_sel = PC_BRANCH;
    else if (Jump)    pc_sel = PC_JUMP;
    else if (Stall)   pc_sel = PC_HOLD;
  end

  assign redirect        = (pc_sel == PC_BRANCH) || (pc_sel == PC_JUMP);
  assign redirect_target = (pc_sel == PC_BRANCH) ? BranchTarget : JumpTarget;

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_SEQ:              pc_d = pc_q + 32'd4;
      PC_BRANCH, PC_JUMP:  pc_d = word_align(redirect_target);
      PC_HOLD:             pc_d = pc_q;
      default:             pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q <= pc_d;
      if (redirect && (redirect_target[1:0] != 2'b00)) misalign_q <= 1'b1;
      // Only a sequential, unflushed load puts a real instruction into IF/ID.
      if ((pc_sel == PC_SEQ) && !Flush) fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  if_id_reg #(
    .NOP (NOP_INST)
  ) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .hold        (Stall),
    .bubble      (redirect || Flush),
    .pc          (pc_q),
    .inst        (Inst),
    .id_pc       (IF_ID_PC),
    .id_pc_plus4 (IF_ID_PCPlus4),
    .id_inst     (IF_ID_Inst),
    .id_valid    (IF_ID_Valid)
  );

  assign InstAddr       = pc_q;
  assign TargetMisalign = misalign_q;
  assign FetchCount     = fetch_count_q;

endmodule
